mrnw_bank_wr_sched: RTL and testbench

Write-port scheduler in front of a banked 1R1W memory array. It arbitrates NUMWRPT independent write requesters onto NUMVBNK physical bank write ports, allowing at most one write per bank per cycle with per-bank round-robin fairness. After reset it runs an initialization sweep that zeroes every row of every bank, then raises `ready`. Its registered outputs drive the `t1_writeA/t1_addrA/t1_dinA` bank interface directly.

---
 rtl/mrnw_bank_wr_sched.sv | 163 ++++++++++++++++
 tb/tb_mrnw_bank_wr_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrnw_bank_wr_sched.sv
// Purpose : per-bank round-robin scheduler of NUMWRPT write requesters onto NUMVBNK 1R1W bank write ports,
//           preceded by an optional zeroing sweep of every row after reset.
// Latency : grant (wr_vld & wr_rdy) in cycle N -> bank write on t1_* in cycle N+1.
// Backpr. : losers see wr_rdy=0 and must hold their request; nothing is buffered; banks never push back.
//
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   ready             high once the sweep is finished and writes are accepted
//   wr_vld/wr_rdy     per-requester handshake; wr_adr = {row, bank}, din = write data
//   t1_writeA/AddrA/dinA  registered bank write port (one lane per bank)
//   stall_cnt         saturating count of RUN cycles with at least one refused request
module mrnw_bank_wr_sched #(
    parameter int WIDTH    = 32,
    parameter int NUMWRPT  = 3,
    parameter int BITADDR  = 13,
    parameter int NUMVROW  = 1024,
    parameter int BITVROW  = 10,
    parameter int NUMVBNK  = 8,
    parameter int BITVBNK  = 3,
    parameter int RST_INIT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         ready,
    input  logic [NUMWRPT-1:0]           wr_vld,
    output logic [NUMWRPT-1:0]           wr_rdy,
    input  logic [NUMWRPT*BITADDR-1:0]   wr_adr,
    input  logic [NUMWRPT*WIDTH-1:0]     din,
    output logic [NUMVBNK-1:0]           t1_writeA,
    output logic [NUMVBNK*BITVROW-1:0]   t1_addrA,
    output logic [NUMVBNK*WIDTH-1:0]     t1_dinA,
    output logic [15:0]                  stall_cnt
);

    localparam int PW = (NUMWRPT > 1) ? $clog2(NUMWRPT) : 1;
    // One spare bit so the counter can sit on NUMVROW for the cycle between the last sweep write and ready.
    localparam int CW = BITVROW + 1;
    localparam logic [CW-1:0] SWEEP_END = CW'(NUMVROW);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                       r_state;
    logic [CW-1:0]                r_row;
    logic                         r_ready;
    logic [PW-1:0]                r_ptr [NUMVBNK];
    logic [NUMVBNK-1:0]           r_writeA;
    logic [NUMVBNK*BITVROW-1:0]   r_addrA;
    logic [NUMVBNK*WIDTH-1:0]     r_dinA;
    logic [15:0]                  r_stall;

    logic [BITVBNK-1:0]           w_req_bnk [NUMWRPT];
    logic [BITVROW-1:0]           w_req_row [NUMWRPT];
    logic [NUMWRPT-1:0]           w_rdy;
    logic [NUMVBNK-1:0]           w_bnk_gnt;
    logic [PW-1:0]                w_bnk_win [NUMVBNK];
    logic [BITVROW-1:0]           w_bnk_row [NUMVBNK];
    logic [WIDTH-1:0]             w_bnk_din [NUMVBNK];
    logic                         w_stall;

    // Split each requester address into bank select (low bits) and row.
    always_comb begin
        for (int i = 0; i < NUMWRPT; i++) begin
            w_req_bnk[i] = wr_adr[i*BITADDR +: BITVBNK];
            w_req_row[i] = wr_adr[i*BITADDR+BITVBNK +: BITVROW];
        end
    end

    // Per-bank round robin: first pass looks at requesters at or above ptr,
    // second pass wraps to the lowest candidate if the first pass found none.
    always_comb begin
        w_rdy     = '0;
        w_bnk_gnt = '0;
        for (int b = 0; b < NUMVBNK; b++) begin
            w_bnk_win[b] = '0;
            w_bnk_row[b] = '0;
            w_bnk_din[b] = '0;
        end
        if (r_state == ST_RUN) begin
            for (int b = 0; b < NUMVBNK; b++) begin
                for (int i = 0; i < NUMWRPT; i++) begin
                    if (!w_bnk_gnt[b] && wr_vld[i] && (w_req_bnk[i] == BITVBNK'(b)) &&
                        (PW'(i) >= r_ptr[b])) begin
                        w_bnk_gnt[b] = 1'b1;
                        w_bnk_win[b] = PW'(i);
                        w_bnk_row[b] = w_req_row[i];
                        w_bnk_din[b] = din[i*WIDTH +: WIDTH];
                        w_rdy[i]     = 1'b1;
                    end
                end
                for (int i = 0; i < NUMWRPT; i++) begin
                    if (!w_bnk_gnt[b] && wr_vld[i] && (w_req_bnk[i] == BITVBNK'(b))) begin
                        w_bnk_gnt[b] = 1'b1;
                        w_bnk_win[b] = PW'(i);
                        w_bnk_row[b] = w_req_row[i];
                        w_bnk_din[b] = din[i*WIDTH +: WIDTH];
                        w_rdy[i]     = 1'b1;
                    end
                end
            end
        end
    end

    assign w_stall = (r_state == ST_RUN) && ((wr_vld & ~w_rdy) != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_INIT;
            r_row    <= '0;
            r_ready  <= 1'b0;
            r_writeA <= '0;
            r_addrA  <= '0;
            r_dinA   <= '0;
            r_stall  <= '0;
            for (int b = 0; b < NUMVBNK; b++) begin
                r_ptr[b] <= '0;
            end
        end else begin
            case (r_state)
                ST_INIT: begin
                    if ((RST_INIT == 0) || (r_row == SWEEP_END)) begin
                        r_state  <= ST_RUN;
                        r_ready  <= 1'b1;
                        r_writeA <= '0;
                    end else begin
                        // Sweep: same row written with zero in every bank at once.
                        r_writeA <= '1;
                        r_dinA   <= '0;
                        for (int b = 0; b < NUMVBNK; b++) begin
                            r_addrA[b*BITVROW +: BITVROW] <= r_row[BITVROW-1:0];
                        end
                        r_row <= r_row + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_writeA <= w_bnk_gnt;
                    for (int b = 0; b < NUMVBNK; b++) begin
                        // Idle lanes keep their last address/data so the bank inputs stay quiet.
                        if (w_bnk_gnt[b]) begin
                            r_addrA[b*BITVROW +: BITVROW] <= w_bnk_row[b];
                            r_dinA[b*WIDTH +: WIDTH]      <= w_bnk_din[b];
                            r_ptr[b] <= (w_bnk_win[b] == PW'(NUMWRPT - 1)) ? '0 : w_bnk_win[b] + 1'b1;
                        end
                    end
                    if (w_stall && (r_stall != 16'hFFFF)) begin
                        r_stall <= r_stall + 16'd1;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign ready     = r_ready;
    assign wr_rdy    = w_rdy;
    assign t1_writeA = r_writeA;
    assign t1_addrA  = r_addrA;
    assign t1_dinA   = r_dinA;
    assign stall_cnt = r_stall;

endmodule

// File: tb/tb_mrnw_bank_wr_sched.sv
// Purpose : scoreboard bench for mrnw_bank_wr_sched (sweep, directed conflicts, random traffic, saturation, mid-sweep reset).
// Latency : expectations for bank writes are stamped with the cycle after the grant.
// Backpr. : drives the hold-while-refused rule itself, using its own model's grant decisions.
module tb_mrnw_bank_wr_sched;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int BA = 13;
    localparam int NR = 1024;
    localparam int BR = 10;
    localparam int NB = 8;
    localparam int BB = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              ready;
    logic [N-1:0]      wr_vld;
    logic [N-1:0]      wr_rdy;
    logic [N*BA-1:0]   wr_adr;
    logic [N*W-1:0]    din;
    logic [NB-1:0]     t1_writeA;
    logic [NB*BR-1:0]  t1_addrA;
    logic [NB*W-1:0]   t1_dinA;
    logic [15:0]       stall_cnt;

    // Second instance without the sweep; its requesters stay idle.
    logic              z_ready;
    logic [N-1:0]      z_vld = '0;
    logic [N-1:0]      z_rdy;
    logic [N*BA-1:0]   z_adr = '0;
    logic [N*W-1:0]    z_din = '0;
    logic [NB-1:0]     z_writeA;
    logic [NB*BR-1:0]  z_addrA;
    logic [NB*W-1:0]   z_dinA;
    logic [15:0]       z_stall;

    always #5 clk = ~clk;

    mrnw_bank_wr_sched #(.WIDTH(W), .NUMWRPT(N), .BITADDR(BA), .NUMVROW(NR), .BITVROW(BR),
                         .NUMVBNK(NB), .BITVBNK(BB), .RST_INIT(1)) u_dut (
        .clk(clk), .rst(rst), .ready(ready), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_adr(wr_adr),
        .din(din), .t1_writeA(t1_writeA), .t1_addrA(t1_addrA), .t1_dinA(t1_dinA), .stall_cnt(stall_cnt));

    mrnw_bank_wr_sched #(.WIDTH(W), .NUMWRPT(N), .BITADDR(BA), .NUMVROW(NR), .BITVROW(BR),
                         .NUMVBNK(NB), .BITVBNK(BB), .RST_INIT(0)) u_noinit (
        .clk(clk), .rst(rst), .ready(z_ready), .wr_vld(z_vld), .wr_rdy(z_rdy), .wr_adr(z_adr),
        .din(z_din), .t1_writeA(z_writeA), .t1_addrA(z_addrA), .t1_dinA(z_dinA), .stall_cnt(z_stall));

    typedef struct {
        int               cyc;
        logic [NB-1:0]    we;
        logic [NB*BR-1:0] addr;
        logic [NB*W-1:0]  dat;
    } wexp_t;

    wexp_t        q_wr[$];
    logic [N-1:0] q_rdy[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int m_stall_cur = 0;
    int m_stall_nxt = 0;
    int m_ptr [NB];
    logic [NB*BR-1:0] m_addr = '0;
    logic [NB*W-1:0]  m_dat = '0;
    bit mon_en = 1'b0;

    logic [N-1:0]    s_vld = '0;
    logic [N*BA-1:0] s_adr = '0;
    logic [N*W-1:0]  s_din = '0;
    logic [N-1:0]    g;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    // Cycle counter since reset release and the stall count the DUT should show this cycle.
    always @(posedge clk) begin
        if (!rst) begin
            cyc <= 0;
            m_stall_cur <= 0;
        end else begin
            cyc <= cyc + 1;
            m_stall_cur <= m_stall_nxt;
        end
    end

    // Reference model: per bank, the candidate closest at-or-after the pointer (mod N) wins.
    task automatic issue(input logic [N-1:0] vld, input logic [N*BA-1:0] adr,
                         input logic [N*W-1:0] dat, output logic [N-1:0] gnt);
        logic [NB-1:0] we;
        int best, bestd, d, bank;
        bit rdy_now;
        wr_vld = vld;
        wr_adr = adr;
        din    = dat;
        gnt    = '0;
        we     = '0;
        rdy_now = (cyc >= NR + 1);
        if (rdy_now) begin
            for (int b = 0; b < NB; b++) begin
                best  = -1;
                bestd = N;
                for (int i = 0; i < N; i++) begin
                    bank = int'(adr[i*BA +: BB]);
                    if (vld[i] && bank == b) begin
                        d = (i - m_ptr[b] + N) % N;
                        if (d < bestd) begin
                            bestd = d;
                            best  = i;
                        end
                    end
                end
                if (best >= 0) begin
                    gnt[best] = 1'b1;
                    m_ptr[b]  = (best + 1) % N;
                    we[b]     = 1'b1;
                    m_addr[b*BR +: BR] = adr[best*BA+BB +: BR];
                    m_dat[b*W +: W]    = dat[best*W +: W];
                end
            end
        end
        q_rdy.push_back(gnt);
        if (we != '0) q_wr.push_back('{cyc: cyc + 1, we: we, addr: m_addr, dat: m_dat});
        if (rdy_now && ((vld & ~gnt) != '0)) m_stall_nxt = (m_stall_cur >= 65535) ? 65535 : m_stall_cur + 1;
        else m_stall_nxt = m_stall_cur;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge that sampled rst=0: restart model and expect a full sweep.
    task automatic release_rst();
        logic [N-1:0] gg;
        q_wr.delete();
        q_rdy.delete();
        for (int b = 0; b < NB; b++) m_ptr[b] = 0;
        m_stall_nxt = 0;
        rst = 1'b1;
        for (int r = 0; r < NR; r++) begin
            for (int b = 0; b < NB; b++) m_addr[b*BR +: BR] = BR'(r);
            q_wr.push_back('{cyc: r + 1, we: '1, addr: m_addr, dat: '0});
        end
        m_dat = '0;
        issue('0, s_adr, s_din, gg);
    endtask

    task automatic do_reset();
        logic [N-1:0] gg;
        rst = 1'b0;
        issue('0, s_adr, s_din, gg);
        next();
        release_rst();
    endtask

    // Random traffic; refused requesters hold everything, others re-roll.
    task automatic rand_step(input int bmax);
        logic [BR-1:0] row;
        logic [BB-1:0] bk;
        next();
        issue(s_vld, s_adr, s_din, g);
        for (int i = 0; i < N; i++) begin
            if (g[i] || !s_vld[i]) begin
                s_vld[i] = ($urandom_range(0, 3) != 0);
                row = BR'($urandom_range(0, NR - 1));
                bk  = BB'($urandom_range(0, bmax));
                s_adr[i*BA +: BA] = {row, bk};
                s_din[i*W +: W]   = $urandom;
            end
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] er;
        wexp_t ew;
        if (mon_en) begin
            if (q_rdy.size() > 0) begin
                er = q_rdy.pop_front();
                check("wr_rdy", wr_rdy, er);
            end
            check("ready", ready, (cyc >= NR + 1));
            check("stall_cnt", stall_cnt, m_stall_cur);
            if (t1_writeA != '0) begin
                if (q_wr.size() == 0) begin
                    check("unexpected_write", t1_writeA, '0);
                end else begin
                    ew = q_wr.pop_front();
                    check("write_cycle", cyc, ew.cyc);
                    check("t1_writeA", t1_writeA, ew.we);
                    check("t1_addrA", t1_addrA, ew.addr);
                    check("t1_dinA", t1_dinA, ew.dat);
                end
            end else if (q_wr.size() > 0 && q_wr[0].cyc <= cyc) begin
                ew = q_wr.pop_front();
                check("missed_write", t1_writeA, ew.we);
            end
            check("noinit_ready", z_ready, (cyc >= 1));
            check("noinit_writeA", z_writeA, '0);
        end
    end

    initial begin
        for (int b = 0; b < NB; b++) m_ptr[b] = 0;
        rst = 1'b0;
        wr_vld = '0;
        wr_adr = '0;
        din = '0;
        next();
        mon_en = 1'b1;
        next();
        release_rst();

        // Sweep with held requests: none may be granted before ready.
        for (int k = 0; k < 2 * NR && cyc < NR; k++) rand_step(7);

        // First RUN cycle: three requesters, three different banks.
        next();
        issue(3'b111, {13'h003, 13'h002, 13'h001}, {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, g);
        check("no_conflict_grant", g, 3'b111);

        // Three-way conflict on bank 5, held for four cycles.
        for (int k = 0; k < 4; k++) begin
            next();
            issue(3'b111, {13'h015, 13'h00D, 13'h005}, {32'h5555_0002, 32'h5555_0001, 32'h5555_0000}, g);
        end
        // Requester 1 alone moves ptr[5] to 2; then 0 vs 2.
        next();
        issue(3'b010, {13'h015, 13'h00D, 13'h005}, {32'h5555_0002, 32'h5555_0011, 32'h5555_0000}, g);
        for (int k = 0; k < 2; k++) begin
            next();
            issue(3'b101, {13'h01D, 13'h00D, 13'h025}, {32'h6666_0002, 32'h0, 32'h6666_0000}, g);
        end

        // Random traffic: narrow bank range for conflicts, then full range.
        for (int k = 0; k < 800; k++) rand_step(2);
        for (int k = 0; k < 700; k++) rand_step(7);

        // Permanent two-way conflict on bank 5 until stall_cnt saturates.
        s_adr = {13'h015, 13'h00D, 13'h005};
        s_din = {32'h0, 32'h7777_0001, 32'h7777_0000};
        for (int k = 0; k < 65600; k++) begin
            next();
            issue(3'b011, s_adr, s_din, g);
            for (int i = 0; i < 2; i++) if (g[i]) s_din[i*W +: W] = $urandom;
        end
        next();
        issue('0, s_adr, s_din, g);
        check("stall_saturated", stall_cnt, 16'hFFFF);

        // Reset while the sweep shows row 300, then a full sweep again.
        next();
        do_reset();
        s_vld = '0;
        for (int k = 0; k < 2 * NR && cyc < 301; k++) rand_step(7);
        do_reset();
        for (int k = 0; k < 2 * NR && cyc < NR; k++) rand_step(7);
        for (int k = 0; k < 200; k++) rand_step(7);

        for (int k = 0; k < 4; k++) begin
            next();
            issue('0, s_adr, s_din, g);
        end
        check("write_queue_drained", q_wr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
